// File: rtl/vram_pkg.sv
// Shared types and constants for the text-mode VRAM arbiter.
// Holds the CPU FSM states, the fixed access latencies and the 80x25 screen geometry.
package vram_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_ISSUE,
    C_WAIT,
    C_DONE
  } cpu_state_t;

  localparam int VID_LATENCY    = 3;
  localparam int CPU_WR_LATENCY = 2;
  localparam int CPU_RD_LATENCY = 3;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 25;
  localparam int TEXT_BYTES = TEXT_COLS * TEXT_ROWS * 2;

  localparam int STARVE_W = 8;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] value);
    return (&value) ? value : value + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Shares the single-port text VRAM between the CGA scanout fetcher and the CPU port.
// Scanout always wins a slot; the CPU is served in free cycles through a req/ack handshake.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 200
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_starve,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  cpu_state_t             cpu_state;
  logic                   cpu_we_q;
  logic [STARVE_W-1:0]    starve_cnt;
  logic [VID_LATENCY-2:0] vid_pipe;
  logic                   cpu_grant;
  logic                   cpu_denied;

  assign cpu_grant  = !vid_req && cpu_req && (cpu_state == C_IDLE);
  assign cpu_denied =  vid_req && cpu_req && (cpu_state == C_IDLE);

  // RAM port: video takes the slot whenever it asks, otherwise an idle CPU request
  always_ff @(posedge clock_25) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (vid_req) begin
        mem_addr <= vid_addr;
      end else if (cpu_grant) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Video return path: fixed depth, independent of anything the CPU does
  always_ff @(posedge clock_25) begin
    if (reset) begin
      vid_pipe  <= '0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      vid_pipe  <= {vid_pipe[VID_LATENCY-3:0], vid_req};
      vid_valid <= vid_pipe[VID_LATENCY-2];
      if (vid_pipe[VID_LATENCY-2]) begin
        vid_data <= mem_rdata;
      end
    end
  end

  // CPU handshake; C_DONE waits for req to fall so one request never runs twice
  always_ff @(posedge clock_25) begin
    if (reset) begin
      cpu_state <= C_IDLE;
      cpu_we_q  <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (cpu_state)
        C_IDLE: begin
          if (cpu_grant) begin
            cpu_state <= C_ISSUE;
            cpu_we_q  <= cpu_we;
          end
        end
        C_ISSUE: begin
          cpu_state <= C_WAIT;
          if (cpu_we_q) begin
            cpu_ack <= 1'b1;
          end
        end
        C_WAIT: begin
          cpu_state <= C_DONE;
          if (!cpu_we_q) begin
            cpu_rdata <= mem_rdata;
            cpu_ack   <= 1'b1;
          end
        end
        C_DONE: begin
          if (!cpu_req) begin
            cpu_state <= C_IDLE;
          end
        end
        default: cpu_state <= C_IDLE;
      endcase
    end
  end

  // Counts slots the CPU lost to video; the flag is sticky until reset
  always_ff @(posedge clock_25) begin
    if (reset) begin
      starve_cnt <= '0;
      cpu_starve <= 1'b0;
    end else begin
      if (cpu_grant) begin
        starve_cnt <= '0;
      end else if (cpu_denied) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
      if (int'(starve_cnt) == STARVE_LIMIT) begin
        cpu_starve <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
// RAM starts with every byte equal to the low byte of its address.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 8;
  localparam int STARVE_LIMIT = 200;

  logic              clock_25 = 1'b0;
  logic              reset;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_starve;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;
  int ack_count;

  vram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock_25(clock_25),
    .reset(reset),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_data(vid_data),
    .vid_valid(vid_valid),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack),
    .cpu_starve(cpu_starve),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #20 clock_25 = ~clock_25;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = i[7:0];
  end

  always @(posedge clock_25) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clock_25);
    #1;
  endtask

  task automatic applyStimulus(input logic vreq, input logic [ADDR_W-1:0] vaddr,
                               input logic creq, input logic cwe,
                               input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cwdata);
    vid_req   = vreq;
    vid_addr  = vaddr;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwdata;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem_addr"},   32'(mem_addr),   32'h0);
    checkOutput({tag, " mem_we"},     32'(mem_we),     32'h0);
    checkOutput({tag, " mem_wdata"},  32'(mem_wdata),  32'h0);
    checkOutput({tag, " vid_valid"},  32'(vid_valid),  32'h0);
    checkOutput({tag, " vid_data"},   32'(vid_data),   32'h0);
    checkOutput({tag, " cpu_ack"},    32'(cpu_ack),    32'h0);
    checkOutput({tag, " cpu_rdata"},  32'(cpu_rdata),  32'h0);
    checkOutput({tag, " cpu_starve"}, 32'(cpu_starve), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    tick;
    checkAllZero("reset");
    reset = 1'b0;
    tick;

    $display("[TB] lone CPU write");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 12'h0A0, 8'h41);
    tick;
    checkOutput("wr mem_we N+1",    32'(mem_we),    32'h1);
    checkOutput("wr mem_addr N+1",  32'(mem_addr),  32'h0A0);
    checkOutput("wr mem_wdata N+1", 32'(mem_wdata), 32'h41);
    checkOutput("wr ack N+1",       32'(cpu_ack),   32'h0);
    tick;
    checkOutput("wr ack N+2",       32'(cpu_ack),   32'h1);
    checkOutput("wr mem_we N+2",    32'(mem_we),    32'h0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    checkOutput("wr ack N+3",       32'(cpu_ack),   32'h0);
    checkOutput("wr mem_we N+3",    32'(mem_we),    32'h0);
    tick;
    tick;

    $display("[TB] CPU read back");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 12'h0A0, 8'h00);
    tick;
    checkOutput("rd ack N+1",    32'(cpu_ack), 32'h0);
    checkOutput("rd mem_we N+1", 32'(mem_we),  32'h0);
    tick;
    checkOutput("rd ack N+2",    32'(cpu_ack), 32'h0);
    tick;
    checkOutput("rd ack N+3",    32'(cpu_ack),   32'h1);
    checkOutput("rd data N+3",   32'(cpu_rdata), 32'h41);
    ack_count = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (cpu_ack) ack_count++;
    end
    checkOutput("rd held req extra acks", 32'(ack_count), 32'h0);
    checkOutput("rd data holds",          32'(cpu_rdata), 32'h41);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    tick;

    $display("[TB] video burst of 8");
    for (int t = 0; t < 12; t++) begin
      checkOutput($sformatf("burst valid t%0d", t), 32'(vid_valid), 32'((t >= VID_LATENCY) && (t < 8 + VID_LATENCY)));
      if ((t >= VID_LATENCY) && (t < 8 + VID_LATENCY))
        checkOutput($sformatf("burst data t%0d", t), 32'(vid_data), 32'(t - VID_LATENCY));
      applyStimulus(t < 8, 12'(t), 1'b0, 1'b0, '0, '0);
      tick;
    end

    $display("[TB] CPU read during video burst");
    for (int t = 0; t < 11; t++) begin
      checkOutput($sformatf("mix valid t%0d", t), 32'(vid_valid), 32'((t >= 3) && (t < 8)));
      if ((t >= 3) && (t < 8))
        checkOutput($sformatf("mix data t%0d", t), 32'(vid_data), 32'(16 + t - 3));
      checkOutput($sformatf("mix ack t%0d", t), 32'(cpu_ack), 32'(t == 5 + CPU_RD_LATENCY));
      if (t == 6) begin
        checkOutput("mix mem_addr", 32'(mem_addr), 32'h0A0);
        checkOutput("mix mem_we",   32'(mem_we),   32'h0);
      end
      if (t == 8) checkOutput("mix rdata", 32'(cpu_rdata), 32'h41);
      applyStimulus(t < 5, 12'(16 + t), (t >= 1) && (t < 9), 1'b0, 12'h0A0, 8'h00);
      tick;
    end
    tick;

    $display("[TB] starvation");
    ack_count = 0;
    for (int t = 0; t < 254; t++) begin
      if (t == 195) checkOutput("starve early", 32'(cpu_starve), 32'h0);
      if (t == 210) checkOutput("starve set",   32'(cpu_starve), 32'h1);
      if (t == 251) begin
        checkOutput("starve wr mem_we",    32'(mem_we),    32'h1);
        checkOutput("starve wr mem_addr",  32'(mem_addr),  32'h100);
        checkOutput("starve wr mem_wdata", 32'(mem_wdata), 32'h55);
      end
      if (t == 250 + CPU_WR_LATENCY) begin
        checkOutput("starve late ack",    32'(cpu_ack),    32'h1);
        checkOutput("starve after serve", 32'(cpu_starve), 32'h1);
      end else if (cpu_ack) begin
        ack_count++;
      end
      applyStimulus(t < 250, 12'h000, t < 253, 1'b1, 12'h100, 8'h55);
      tick;
    end
    checkOutput("starve stray acks", 32'(ack_count), 32'h0);
    tick;
    tick;

    $display("[TB] reset during CPU read");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 12'h0A0, 8'h00);
    tick;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    reset = 1'b0;
    checkAllZero("midreset");
    tick;
    checkOutput("midreset ack +1", 32'(cpu_ack), 32'h0);
    tick;
    checkOutput("midreset ack +2", 32'(cpu_ack), 32'h0);

    applyStimulus(1'b0, '0, 1'b1, 1'b0, 12'h005, 8'h00);
    tick;
    checkOutput("post reset ack N+1", 32'(cpu_ack), 32'h0);
    tick;
    checkOutput("post reset ack N+2", 32'(cpu_ack), 32'h0);
    tick;
    checkOutput("post reset ack N+3",  32'(cpu_ack),   32'h1);
    checkOutput("post reset rdata",    32'(cpu_rdata), 32'h05);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
